// File: rtl/studio2_keypad.sv
// studio2_keypad: PS/2-driven keypad state for two Studio II pads, answered on active-low EF3/EF4
module studio2_keypad #(
    parameter logic [2:0]  OUT_PORT    = 3'd2,
    parameter logic [15:0] HOLD_CYCLES = 16'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] ps2_key,
    input  logic        io_out,
    input  logic [2:0]  io_n,
    input  logic [7:0]  io_dout,
    output logic [3:0]  key_latch,
    output logic        ef3_n,
    output logic        ef4_n,
    output logic [9:0]  kp1_state,
    output logic [9:0]  kp2_state,
    output logic        any_key
);
    // scan codes, key k at bits [8k+7:8k]: keys 0..9 are pad 1 digits, 10..19 are pad 2 digits
    localparam logic [159:0] CODES = {
        8'h7D, 8'h75, 8'h6C, 8'h74, 8'h73, 8'h6B, 8'h7A, 8'h72, 8'h69, 8'h70,
        8'h46, 8'h3E, 8'h3D, 8'h36, 8'h2E, 8'h25, 8'h26, 8'h1E, 8'h16, 8'h45
    };
    logic        shadow;
    logic        ev;
    logic [19:0] state;
    logic [9:0]  sel;
    logic        unused;
    assign ev        = ps2_key[10] != shadow;
    assign kp1_state = state[9:0];
    assign kp2_state = state[19:10];
    assign any_key   = |state;
    assign sel       = 10'd1 << key_latch;
    assign unused    = ^io_dout[7:4];
    // toggle shadow follows the bus every cycle, reset included, so reset never produces an event
    always_ff @(posedge clk)
        shadow <= ps2_key[10];
    for (genvar k = 0; k < 20; k++) begin : g_key
        logic        hit;
        logic        make;
        logic        brk;
        logic        st;
        logic        pend;
        logic [15:0] cnt;
        assign hit      = ev && !ps2_key[8] && ps2_key[7:0] == CODES[k*8 +: 8];
        assign make     = hit && ps2_key[9];
        assign brk      = hit && !ps2_key[9];
        assign state[k] = st;
        // key down on make; a break releases at once or is deferred until the hold count expires
        always_ff @(posedge clk) begin
            if (reset) begin
                st   <= 1'b0;
                pend <= 1'b0;
                cnt  <= 16'd0;
            end else if (make) begin
                st   <= 1'b1;
                pend <= 1'b0;
                cnt  <= HOLD_CYCLES;
            end else begin
                if (cnt != 16'd0)
                    cnt <= cnt - 16'd1;
                if (brk && cnt == 16'd0)
                    st <= 1'b0;
                else if ((brk || pend) && cnt == 16'd1) begin
                    st   <= 1'b0;
                    pend <= 1'b0;
                end else if (brk)
                    pend <= 1'b1;
            end
        end
    end
    // CPU key latch and registered flag answers; out-of-range latch values select no key
    always_ff @(posedge clk) begin
        if (reset) begin
            key_latch <= 4'd0;
            ef3_n     <= 1'b1;
            ef4_n     <= 1'b1;
        end else begin
            if (io_out && io_n == OUT_PORT)
                key_latch <= io_dout[3:0];
            ef3_n <= ~|(kp1_state & sel);
            ef4_n <= ~|(kp2_state & sel);
        end
    end
endmodule

// File: tb/tb_studio2_keypad.sv
// tb_studio2_keypad: random and directed stimulus against an event-time model of the keypad responder
module tb_studio2_keypad;
    localparam int HOLD1 = 100;
    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] ps2_key;
    logic        io_out;
    logic [2:0]  io_n;
    logic [7:0]  io_dout;
    logic [3:0]  kl [2];
    logic        e3 [2];
    logic        e4 [2];
    logic [9:0]  k1 [2];
    logic [9:0]  k2 [2];
    logic        ak [2];
    int checks = 0;
    int errors = 0;
    byte unsigned codes [20] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46,
                                 8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D};
    bit       made [20];
    bit       brk [20];
    int       m [20];
    int       b [20];
    int       cyc = 0;
    bit [3:0] lat;
    bit       ef3e [2];
    bit       ef4e [2];
    bit       mtog;

    always #5 clk = ~clk;

    studio2_keypad #(.OUT_PORT(3'd2), .HOLD_CYCLES(16'd0)) dut0 (
        .clk(clk), .reset(reset), .ps2_key(ps2_key), .io_out(io_out), .io_n(io_n), .io_dout(io_dout),
        .key_latch(kl[0]), .ef3_n(e3[0]), .ef4_n(e4[0]), .kp1_state(k1[0]), .kp2_state(k2[0]), .any_key(ak[0]));

    studio2_keypad #(.OUT_PORT(3'd2), .HOLD_CYCLES(16'd100)) dut1 (
        .clk(clk), .reset(reset), .ps2_key(ps2_key), .io_out(io_out), .io_n(io_n), .io_dout(io_dout),
        .key_latch(kl[1]), .ef3_n(e3[1]), .ef4_n(e4[1]), .kp1_state(k1[1]), .kp2_state(k2[1]), .any_key(ak[1]));

    // a key reads down from its make until max(break edge, make edge + hold)
    function automatic bit [9:0] st_vec(int pad, int h, int c);
        bit [9:0] v = '0;
        for (int d = 0; d < 10; d++) begin
            int k = pad * 10 + d;
            int rel = (b[k] > m[k] + h) ? b[k] : m[k] + h;
            v[d] = made[k] && (!brk[k] || c < rel);
        end
        return v;
    endfunction

    task automatic check(string tag, logic [15:0] obs, logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int e = cyc + 1;
        if (reset) begin
            lat = 4'd0;
            for (int d = 0; d < 2; d++) begin
                ef3e[d] = 1'b1;
                ef4e[d] = 1'b1;
            end
            for (int k = 0; k < 20; k++) begin
                made[k] = 1'b0;
                brk[k]  = 1'b0;
            end
            mtog = ps2_key[10];
        end else begin
            for (int d = 0; d < 2; d++) begin
                bit [9:0] s1 = st_vec(0, d ? HOLD1 : 0, cyc);
                bit [9:0] s2 = st_vec(1, d ? HOLD1 : 0, cyc);
                ef3e[d] = !((lat < 4'd10) ? s1[lat] : 1'b0);
                ef4e[d] = !((lat < 4'd10) ? s2[lat] : 1'b0);
            end
            if (ps2_key[10] != mtog && !ps2_key[8])
                for (int k = 0; k < 20; k++)
                    if (codes[k] == ps2_key[7:0]) begin
                        if (ps2_key[9]) begin
                            made[k] = 1'b1;
                            brk[k]  = 1'b0;
                            m[k]    = e;
                        end else if (made[k] && !brk[k]) begin
                            brk[k] = 1'b1;
                            b[k]   = e;
                        end
                    end
            mtog = ps2_key[10];
            if (io_out && io_n == 3'd2)
                lat = io_dout[3:0];
        end
        cyc = e;
    endtask

    task automatic check_all();
        for (int d = 0; d < 2; d++) begin
            bit [9:0] s1 = st_vec(0, d ? HOLD1 : 0, cyc);
            bit [9:0] s2 = st_vec(1, d ? HOLD1 : 0, cyc);
            check($sformatf("d%0d.latch", d), 16'(kl[d]), 16'(lat));
            check($sformatf("d%0d.kp1", d), 16'(k1[d]), 16'(s1));
            check($sformatf("d%0d.kp2", d), 16'(k2[d]), 16'(s2));
            check($sformatf("d%0d.ef3", d), 16'(e3[d]), 16'(ef3e[d]));
            check($sformatf("d%0d.ef4", d), 16'(e4[d]), 16'(ef4e[d]));
            check($sformatf("d%0d.any", d), 16'(ak[d]), 16'(|{s1, s2}));
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic ps2(bit p, bit x, logic [7:0] code);
        ps2_key = {~ps2_key[10], p, x, code};
        tick();
    endtask

    task automatic out(logic [2:0] port, logic [7:0] data);
        io_out  = 1'b1;
        io_n    = port;
        io_dout = data;
        tick();
        io_out  = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        ps2_key = '0;
        io_out  = 1'b0;
        io_n    = 3'd0;
        io_dout = 8'd0;
        tick();
        tick();
        check("rst.latch", 16'(kl[0]), 16'h0);
        check("rst.ef3", 16'(e3[0]), 16'h1);
        check("rst.ef4", 16'(e4[1]), 16'h1);
        check("rst.any", 16'(ak[1]), 16'h0);
        reset = 1'b0;
        ps2(1'b1, 1'b0, 8'h16);
        check("t1.kp1", 16'(k1[0]), 16'h002);
        out(3'd2, 8'h01);
        check("t1.ef3_lag", 16'(e3[0]), 16'h1);
        tick();
        check("t1.ef3", 16'(e3[0]), 16'h0);
        check("t1.ef4", 16'(e4[0]), 16'h1);
        ps2(1'b1, 1'b0, 8'h6C);
        out(3'd2, 8'h07);
        tick();
        check("t2.ef4_make", 16'(e4[0]), 16'h0);
        ps2(1'b0, 1'b0, 8'h6C);
        check("t2.kp2_break", 16'(k2[0][7]), 16'h0);
        check("t2.ef4_lag", 16'(e4[0]), 16'h0);
        tick();
        check("t2.ef4_break", 16'(e4[0]), 16'h1);
        ps2(1'b1, 1'b0, 8'h2E);
        repeat (4) tick();
        ps2(1'b0, 1'b0, 8'h2E);
        check("t3.d0_released", 16'(k1[0][5]), 16'h0);
        repeat (94) tick();
        check("t3.held_99", 16'(k1[1][5]), 16'h1);
        tick();
        check("t3.released_100", 16'(k1[1][5]), 16'h0);
        for (int k = 0; k < 20; k++)
            ps2(1'b1, 1'b0, codes[k]);
        out(3'd2, 8'h0C);
        tick();
        check("t4.ef3_d0", 16'(e3[0]), 16'h1);
        check("t4.ef4_d0", 16'(e4[0]), 16'h1);
        check("t4.ef3_d1", 16'(e3[1]), 16'h1);
        check("t4.ef4_d1", 16'(e4[1]), 16'h1);
        out(3'd3, 8'h05);
        check("t4.latch_port3", 16'(kl[0]), 16'hC);
        ps2(1'b0, 1'b1, 8'h70);
        check("t5.ext_ignored", 16'(k2[0][0]), 16'h1);
        reset = 1'b1;
        ps2_key = {~ps2_key[10], 1'b1, 1'b0, 8'h45};
        tick();
        reset = 1'b0;
        tick();
        check("t5.no_event_kp1", 16'(k1[0]), 16'h0);
        check("t5.no_event_any", 16'(ak[1]), 16'h0);
        io_out  = 1'b1;
        io_n    = 3'd2;
        io_dout = 8'h03;
        ps2_key = {~ps2_key[10], 1'b1, 1'b0, 8'h26};
        tick();
        io_out = 1'b0;
        check("t6.ef3_1st", 16'(e3[0]), 16'h1);
        tick();
        check("t6.ef3_2nd", 16'(e3[0]), 16'h0);
        ps2(1'b0, 1'b0, 8'h26);
        check("t6.pending", 16'(k1[1][3]), 16'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6.rst_kp1", 16'(k1[1]), 16'h0);
        check("t6.rst_any", 16'(ak[1]), 16'h0);
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 99) < 25) begin
                int kind = $urandom_range(0, 9);
                int k = $urandom_range(0, 19);
                bit p = $urandom_range(0, 2) != 0;
                if (kind == 0)
                    ps2_key = {~ps2_key[10], p, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255))};
                else
                    ps2_key = {~ps2_key[10], p, kind == 1, codes[k]};
            end
            io_out  = $urandom_range(0, 4) == 0;
            io_n    = $urandom_range(0, 1) ? 3'd2 : 3'($urandom_range(0, 7));
            io_dout = 8'($urandom_range(0, 255));
            reset   = $urandom_range(0, 299) == 0;
            tick();
        end
        io_out = 1'b0;
        reset  = 1'b0;
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
